matrix_result_reader: RTL and testbench
=======================================

Name: matrix_result_reader

Overview:
Read-back engine for the matrix-multiplication processor. After `top_processor` finishes, the host pulses `start_read`. The block then walks the result matrix in data memory in row-major order, one element at a time. Each element is presented on a valid/ready output stream with row/column tags. It is the reader counterpart to the processor's result write-back path and sits between data-memory port B and the host/UART transmit side.

Parameters:
- DATA_WIDTH, 8, width of one matrix element / memory word
- ADDR_WIDTH, 8, data-memory address width
- ROWS, 3, result-matrix rows (>=1)
- COLS, 3, result-matrix columns (>=1)
- BASE_ADDR, 0, memory address of element (0,0)

Ports:
- fast_clock  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_read  in  1  request to read the whole matrix; sampled only in IDLE
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after the edge that sampled mem_rd_en=1
- out_data  out  DATA_WIDTH  element value
- out_row  out  clog2(ROWS) (min 1)  row index of out_data
- out_col  out  clog2(COLS) (min 1)  column index of out_data
- out_last  out  1  high with final element (ROWS-1,COLS-1)
- out_valid  out  1  element available
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including out_data, out_row, out_col and mem_addr. Row/col counters 0. Takes effect immediately, even mid-transfer or with out_valid high; the partially read matrix is abandoned.
- FSM states: IDLE, REQ, WAIT, SEND, DONE.
- IDLE:
  - start_read=1 at an edge -> REQ.
  - Counters cleared to (0,0) on that same edge.
- REQ (1 cycle):
  - mem_rd_en=1.
  - mem_addr = BASE_ADDR + row*COLS + col, truncated modulo 2^ADDR_WIDTH (address wrap is legal and silent).
  - -> WAIT.
- WAIT (1 cycle):
  - mem_rd_en=0.
  - At the closing edge, mem_rdata is registered into out_data and out_row/out_col/out_last are registered.
  - -> SEND.
- SEND:
  - out_valid=1. out_data/out_row/out_col/out_last are held stable until accepted.
  - Accept when not last: col+1; on col==COLS-1, col=0 and row+1. -> REQ.
  - Accept when last: -> DONE.
- DONE (1 cycle): done=1, out_valid=0, -> IDLE.
- Timing: first out_valid is 3 cycles after the start_read edge. Minimum 3 cycles per element with out_ready tied high. A full transfer is 3*ROWS*COLS+1 cycles to done.
- Back-pressure: out_ready low holds SEND indefinitely, with no memory traffic.
- start_read while busy: ignored, not queued. start_read during the DONE cycle is also ignored. start_read held high continuously restarts one cycle after DONE (back in IDLE).
- out_ready asserted while out_valid=0: no effect.
- ROWS=COLS=1: a single element, out_last=1 on it.
- mem_rd_en is never asserted outside REQ. At most one read is outstanding.

Decomposition:
- Shared package `mm_pkg`:
  - FSM state enum `rd_state_t` (IDLE, REQ, WAIT, SEND, DONE).
  - DATA_WIDTH/ADDR_WIDTH defaults matching the processor's data memory.
- One natural sub-module: `matrix_index_counter`.
  - Holds the row/col counter with clear, increment and last-flag outputs.
  - Reusable by the processor's write-back side.
- FSM and output register stay in the top.

Test Plan:
- Basic read, ROWS=2, COLS=2, BASE_ADDR=8. Memory model preloaded with 8:0x11, 9:0x22, 10:0x33, 11:0x44; out_ready=1; pulse start_read.
  - mem_addr sequence is 8, 9, 10, 11.
  - Stream is 0x11(0,0), 0x22(0,1), 0x33(1,0), 0x44(1,1,last).
  - First out_valid is 3 cycles after start; done pulses once, 13 cycles after start; busy then drops.
- Back-pressure: as the basic read, but out_ready low for 5 cycles on element 0x22.
  - out_valid and out_data=0x22 stay stable throughout.
  - No mem_rd_en during the stall.
  - Element is accepted on the first ready edge; remaining order unchanged.
- Start while busy: pulse start_read again during the second element.
  - Exactly 4 elements are produced and one done pulse.
  - No restart.
- Address wrap: ADDR_WIDTH=4, BASE_ADDR=14, ROWS=1, COLS=4.
  - mem_addr sequence is 14, 15, 0, 1.
  - out_last is high on the 4th element only.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) while out_valid=1 with row=1.
  - All outputs drop to 0 immediately; no done pulse.
  - After release, a new start_read begins again at address BASE_ADDR with (0,0).

Source files
------------

// File: rtl/matrix_result_reader_pkg.sv
// Shared types for the matrix processor read-back path: reader FSM states,
// default memory geometry and the index-width helper.
package mm_pkg;

  localparam int MM_DATA_WIDTH = 8;
  localparam int MM_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    DONE
  } rd_state_t;

  // A 1-row or 1-column matrix still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) walker over a ROWS x COLS matrix with clear, increment
// and a last-element flag; shared by the read-back and write-back paths.
module matrix_index_counter
  import mm_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int ROW_W = idx_width(ROWS),
  parameter int COL_W = idx_width(COLS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_end, col_end;

  assign row_end = (row_q == ROW_W'(ROWS - 1));
  assign col_end = (col_q == COL_W'(COLS - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = row_end && col_end;

endmodule

// File: rtl/matrix_result_reader.sv
// Walks the result matrix in data memory row-major, one read per element, and
// presents each element with its (row, col) tag on a valid/ready stream.
module matrix_result_reader
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MM_ADDR_WIDTH,
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic                                       fast_clock,
  input  logic                                       rst_n,
  input  logic                                       start_read,
  output logic                                       mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                      mem_addr,
  input  logic [DATA_WIDTH-1:0]                      mem_rdata,
  output logic [DATA_WIDTH-1:0]                      out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
  output logic                                       out_last,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       busy,
  output logic                                       done
);

  localparam int ROW_W = idx_width(ROWS);
  localparam int COL_W = idx_width(COLS);

  rd_state_t        state_q;
  logic             rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             last_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic             cnt_clr, cnt_inc, cnt_last;
  logic [ROW_W-1:0] cnt_row;
  logic [COL_W-1:0] cnt_col;

  assign cnt_clr = (state_q == IDLE) && start_read;
  assign cnt_inc = (state_q == SEND) && out_ready && !last_q;

  matrix_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_idx (
    .clk_i (fast_clock),
    .rst_ni(rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .row_o (cnt_row),
    .col_o (cnt_col),
    .last_o(cnt_last)
  );

  // Row-major layout is contiguous, so BASE + row*COLS + col is simply a
  // running address incremented once per accepted element (wrap is silent).
  always_ff @(posedge fast_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_read) begin
            state_q <= REQ;
            rd_en_q <= 1'b1;
            addr_q  <= ADDR_WIDTH'(BASE_ADDR);
            busy_q  <= 1'b1;
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          state_q <= SEND;
          data_q  <= mem_rdata;
          row_q   <= cnt_row;
          col_q   <= cnt_col;
          last_q  <= cnt_last;
          valid_q <= 1'b1;
        end
        SEND: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= REQ;
              rd_en_q <= 1'b1;
              addr_q  <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Bench for matrix_result_reader: a 2x2 reader at base 8 and a 1x4 reader with
// a 4-bit address bus at base 14, each fed by a one-cycle-latency memory.
module tb_matrix_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, ready, rd_en, row, col, last, valid, busy, done;
  logic [7:0] addr, rdata, data;
  logic       start_w, ready_w, rd_en_w, row_w, last_w, valid_w, busy_w, done_w;
  logic [3:0] addr_w;
  logic [1:0] col_w;
  logic [7:0] rdata_w, data_w;

  logic [7:0] mem   [256];
  logic [7:0] mem_w [16];

  always @(posedge clk) if (rd_en)   rdata   <= mem[addr];
  always @(posedge clk) if (rd_en_w) rdata_w <= mem_w[addr_w];

  matrix_result_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ROWS(2), .COLS(2), .BASE_ADDR(8)) dut (
    .fast_clock(clk), .rst_n(rst_n), .start_read(start), .mem_rd_en(rd_en), .mem_addr(addr),
    .mem_rdata(rdata), .out_data(data), .out_row(row), .out_col(col), .out_last(last),
    .out_valid(valid), .out_ready(ready), .busy(busy), .done(done));

  matrix_result_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ROWS(1), .COLS(4), .BASE_ADDR(14)) dut_w (
    .fast_clock(clk), .rst_n(rst_n), .start_read(start_w), .mem_rd_en(rd_en_w), .mem_addr(addr_w),
    .mem_rdata(rdata_w), .out_data(data_w), .out_row(row_w), .out_col(col_w), .out_last(last_w),
    .out_valid(valid_w), .out_ready(ready_w), .busy(busy_w), .done(done_w));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         r;
    int         c;
    logic       l;
  } elem_t;

  typedef struct {
    int a;
    logic [7:0] d;
    int r;
    int c;
    logic l;
  } vec_t;

  typedef struct {
    int stall_k;
    int stall_len;
    bit rstart;
    bit poke;
    int pct;
    int exp_done;
  } scen_t;

  int    g_addr[$];
  elem_t g_el[$];
  int    first_t, done_t, done_cnt, stall_bad, stall_rd;

  // Reference: element i of a ROWSxCOLS matrix lives at BASE + r*COLS + c.
  function automatic int model_addr(input int i, input int base, input int cols, input int aw);
    return (base + (i / cols) * cols + (i % cols)) % (1 << aw);
  endfunction

  task automatic xfer(input int stall_k, input int stall_len, input bit rstart,
                      input bit poke, input int pct);
    int t, st;
    bit poked;
    logic [7:0] hold_d;
    elem_t e;
    g_addr.delete(); g_el.delete();
    first_t = -1; done_t = -1; done_cnt = 0; stall_bad = 0; stall_rd = 0;
    st = 0; poked = 0; hold_d = '0;
    @(negedge clk); start = 1'b1; ready = 1'b0;
    @(posedge clk); t = 1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en) g_addr.push_back(int'(addr));
      if (valid && first_t < 0) first_t = t;
      if (done) begin
        done_cnt++; done_t = t;
        if (poke) start = 1'b1;
      end
      if (!busy && done_cnt > 0) break;
      if (t > 150) begin
        check("xfer_timeout", 64'(t), 64'd0);
        break;
      end
      if (!valid && st > 0 && st < stall_len) stall_bad++;
      ready = 1'($urandom_range(1));
      if (valid) begin
        if (g_el.size() == stall_k && st < stall_len) begin
          if (st == 0) hold_d = data;
          else if (data !== hold_d) stall_bad++;
          if (rd_en) stall_rd++;
          ready = 1'b0;
          st++;
        end else begin
          ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
        end
        if (rstart && !poked && g_el.size() == 1) begin
          start = 1'b1;
          poked = 1;
        end
        if (ready) begin
          e.d = data; e.r = int'(row); e.c = int'(col); e.l = last;
          g_el.push_back(e);
        end
      end
      @(posedge clk);
      t++;
    end
    ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int a;
    check({tag, "_n_elem"}, 64'(g_el.size()), 64'd4);
    check({tag, "_n_reads"}, 64'(g_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < g_el.size() && i < g_addr.size(); i++) begin
      a = model_addr(i, 8, 2, 8);
      check($sformatf("%s_addr%0d", tag, i), 64'(g_addr[i]), 64'(a));
      check($sformatf("%s_data%0d", tag, i), 64'(g_el[i].d), 64'(mem[a]));
      check($sformatf("%s_row%0d", tag, i), 64'(g_el[i].r), 64'(i / 2));
      check($sformatf("%s_col%0d", tag, i), 64'(g_el[i].c), 64'(i % 2));
      check($sformatf("%s_last%0d", tag, i), 64'(g_el[i].l), 64'(i == 3));
    end
  endtask

  vec_t  basic[4];
  scen_t scen[8];

  initial begin
    basic[0] = '{8,  8'h11, 0, 0, 1'b0};
    basic[1] = '{9,  8'h22, 0, 1, 1'b0};
    basic[2] = '{10, 8'h33, 1, 0, 1'b0};
    basic[3] = '{11, 8'h44, 1, 1, 1'b1};
    scen[0] = '{-1, 0, 0, 0, 100, 13};
    scen[1] = '{ 1, 5, 0, 0, 100, 18};
    scen[2] = '{-1, 0, 1, 0, 100, 13};
    scen[3] = '{-1, 0, 0, 1, 100, 13};
    scen[4] = '{ 3, 2, 0, 0, 100, 15};
    scen[5] = '{-1, 0, 0, 0,  50, -1};
    scen[6] = '{-1, 0, 0, 0,  30, -1};
    scen[7] = '{ 0, 3, 1, 0,  70, -1};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem_w[i] = 8'($urandom);
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; start_w = 1'b0; ready_w = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_addr",  64'(addr),  64'd0);
    check("rst_data",  64'(data),  64'd0);
    check("rst_rowcol", 64'({row, col, last}), 64'd0);
    rst_n = 1'b1;

    for (int s = 0; s < 8; s++) begin
      if (s < 5) for (int i = 0; i < 4; i++) mem[basic[i].a] = basic[i].d;
      else for (int i = 8; i < 12; i++) mem[i] = 8'($urandom);
      xfer(scen[s].stall_k, scen[s].stall_len, scen[s].rstart, scen[s].poke, scen[s].pct);
      check_stream($sformatf("s%0d", s));
      check($sformatf("s%0d_done_cnt", s), 64'(done_cnt), 64'd1);
      check($sformatf("s%0d_first_valid", s), 64'(first_t), 64'd3);
      if (scen[s].exp_done > 0)
        check($sformatf("s%0d_done_t", s), 64'(done_t), 64'(scen[s].exp_done));
      if (scen[s].stall_len > 0) begin
        check($sformatf("s%0d_stall_stable", s), 64'(stall_bad), 64'd0);
        check($sformatf("s%0d_stall_rd", s), 64'(stall_rd), 64'd0);
      end
      if (s == 0)
        for (int i = 0; i < 4 && i < g_el.size() && i < g_addr.size(); i++) begin
          check($sformatf("vec_addr%0d", i), 64'(g_addr[i]), 64'(basic[i].a));
          check($sformatf("vec_data%0d", i), 64'(g_el[i].d), 64'(basic[i].d));
          check($sformatf("vec_rcl%0d", i), 64'({g_el[i].r, g_el[i].c, 31'd0, g_el[i].l}),
                64'({basic[i].r, basic[i].c, 31'd0, basic[i].l}));
        end
      repeat (2) begin
        @(negedge clk);
        check($sformatf("s%0d_idle_after", s), 64'({busy, rd_en, valid}), 64'd0);
      end
    end

    // start_read held high: one IDLE cycle after DONE, then a fresh read at BASE.
    begin
      int n;
      for (int i = 0; i < 4; i++) mem[basic[i].a] = basic[i].d;
      @(negedge clk); start = 1'b1; ready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 60);
      check("hold_done_seen", 64'(done), 64'd1);
      @(negedge clk);
      check("hold_idle_gap", 64'({busy, rd_en}), 64'd0);
      @(negedge clk);
      check("hold_restart", 64'({busy, rd_en, addr}), 64'({1'b1, 1'b1, 8'd8}));
      start = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 60);
      check("hold_second_done", 64'(done), 64'd1);
      @(negedge clk);
      ready = 1'b0;
    end

    // Asynchronous reset in the middle of row 1.
    begin
      int n, dn;
      @(negedge clk); start = 1'b1; ready = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!(valid && row) && n < 60) begin @(negedge clk); n++; end
      check("rst_mid_reached", 64'({valid, row}), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 64'(valid), 64'd0);
      check("rst_mid_data", 64'(data), 64'd0);
      check("rst_mid_rowcol", 64'({row, col, last}), 64'd0);
      check("rst_mid_ctrl", 64'({busy, done, rd_en}), 64'd0);
      check("rst_mid_addr", 64'(addr), 64'd0);
      ready = 1'b0;
      dn = 0;
      repeat (3) begin @(negedge clk); if (done) dn++; end
      rst_n = 1'b1;
      check("rst_mid_no_done", 64'(dn), 64'd0);
      xfer(-1, 0, 0, 0, 100);
      check_stream("post_rst");
      check("post_rst_done_t", 64'(done_t), 64'd13);
    end

    // Address wrap on the 4-bit bus.
    begin
      int wa[$];
      elem_t we[$];
      elem_t e;
      int n, a;
      @(negedge clk); start_w = 1'b1; ready_w = 1'b1;
      @(negedge clk); start_w = 1'b0;
      n = 0;
      while (!done_w && n < 60) begin
        if (rd_en_w) wa.push_back(int'(addr_w));
        if (valid_w) begin
          e.d = data_w; e.r = int'(row_w); e.c = int'(col_w); e.l = last_w;
          we.push_back(e);
        end
        @(negedge clk); n++;
      end
      check("wrap_done", 64'(done_w), 64'd1);
      check("wrap_n", 64'({32'(wa.size()), 32'(we.size())}), 64'({32'd4, 32'd4}));
      for (int i = 0; i < 4 && i < wa.size() && i < we.size(); i++) begin
        a = model_addr(i, 14, 4, 4);
        check($sformatf("wrap_addr%0d", i), 64'(wa[i]), 64'(a));
        check($sformatf("wrap_data%0d", i), 64'(we[i].d), 64'(mem_w[a]));
        check($sformatf("wrap_rc%0d", i), 64'({we[i].r, we[i].c}), 64'({32'd0, 32'(i)}));
        check($sformatf("wrap_last%0d", i), 64'(we[i].l), 64'(i == 3));
      end
      ready_w = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
